// File: rtl/bid_round_arbiter.sv
// bid_round_arbiter: round-robin bid arbiter for one bids22 auction round; charges fees, tracks the leader,
// settles the winner. Optional idle auto-close is enabled by defining BID_ROUND_TIMEOUT_EN.
module bid_round_arbiter #(
    parameter int DATAWIDTH   = 32,
    parameter int NUMBIDDERS  = 3,
    parameter int IDLETIMEOUT = 16
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             C_start,
    input  logic [NUMBIDDERS-1:0]            mask,
    input  logic [DATAWIDTH-1:0]             bidcost,
    input  logic                             bal_load,
    input  logic [NUMBIDDERS*DATAWIDTH-1:0]  bal_in,
    input  logic [NUMBIDDERS-1:0]            bid_valid,
    input  logic [NUMBIDDERS*DATAWIDTH-1:0]  bid_value,
    output logic [NUMBIDDERS-1:0]            bid_ack,
    output logic [NUMBIDDERS*2-1:0]          bid_err,
    output logic [NUMBIDDERS*DATAWIDTH-1:0]  balance,
    output logic [DATAWIDTH-1:0]             max_bid,
    output logic [NUMBIDDERS-1:0]            win,
    output logic                             round_over,
    output logic                             ready
);

    localparam int DW  = DATAWIDTH;
    localparam int NB  = NUMBIDDERS;
    localparam int PW  = (NB > 1) ? $clog2(NB) : 1;
    localparam int PW1 = PW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUND  = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_LOWBID  = 2'b01,
        ERR_NOFUNDS = 2'b10,
        ERR_MASKED  = 2'b11
    } err_t;

    state_t                 state, state_nxt;
    logic                   c_start_q;
    logic                   start_rise;
    logic                   enter_round;
    logic                   timeout;

    logic [NB-1:0]          mask_q;
    logic [DW-1:0]          cost_q;
    logic [NB-1:0][DW-1:0]  bal;
    logic [NB-1:0][DW-1:0]  bids;
    logic [DW-1:0]          max_q;
    logic [NB-1:0]          win_q;
    logic [NB-1:0]          ack_q;
    logic [NB-1:0][1:0]     err_q;
    logic [PW-1:0]          rr;

    logic [NB-1:0]          eligible;
    logic                   gnt_any;
    logic [PW-1:0]          gnt_idx;
    logic [PW1-1:0]         cand_sum;
    logic [PW-1:0]          cand;

    logic [DW-1:0]          sel_bal;
    logic [DW-1:0]          sel_bid;
    logic [DW:0]            need;
    err_t                   eval_err;
    logic                   charge;

    assign bids        = bid_value;
    assign start_rise  = C_start && !c_start_q;
    assign enter_round = ((state == IDLE) || (state == DONE)) && start_rise;

    // A bidder whose ack is showing this cycle still holds valid; it must not win a second grant.
    assign eligible = bid_valid & ~ack_q;

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        cand_sum = '0;
        cand     = '0;
        for (int k = 0; k < NB; k++) begin
            cand_sum = {1'b0, rr} + PW1'(k);
            if (cand_sum >= PW1'(NB)) begin
                cand_sum = cand_sum - PW1'(NB);
            end
            cand = cand_sum[PW-1:0];
            if (!gnt_any && (state == ROUND) && eligible[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Fee plus bid is compared one bit wider than the data path so it can never wrap.
    always_comb begin
        sel_bal = bal[gnt_idx];
        sel_bid = bids[gnt_idx];
        need    = {1'b0, cost_q} + {1'b0, sel_bid};
        if (!mask_q[gnt_idx]) begin
            eval_err = ERR_MASKED;
        end else if (need > {1'b0, sel_bal}) begin
            eval_err = ERR_NOFUNDS;
        end else if (sel_bid <= max_q) begin
            eval_err = ERR_LOWBID;
        end else begin
            eval_err = ERR_OK;
        end
        charge = (eval_err == ERR_OK) || (eval_err == ERR_LOWBID);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start_rise)           state_nxt = ROUND;
            ROUND:      if (!C_start || timeout)  state_nxt = SETTLE;
            SETTLE:                               state_nxt = DONE;
            default:                              state_nxt = IDLE;
        endcase
    end

`ifdef BID_ROUND_TIMEOUT_EN
    logic [DW-1:0] idle_cnt;

    // The round closes on the edge where the idle count would reach IDLETIMEOUT.
    assign timeout = (state == ROUND) && !gnt_any && ((idle_cnt + 1'b1) == DW'(IDLETIMEOUT));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idle_cnt <= '0;
        end else if (enter_round || gnt_any) begin
            idle_cnt <= '0;
        end else if (state == ROUND) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    logic unused_idletimeout;

    assign timeout            = 1'b0;
    assign unused_idletimeout = ^IDLETIMEOUT;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            c_start_q <= 1'b0;
            mask_q    <= '0;
            cost_q    <= '0;
            bal       <= '0;
            max_q     <= '0;
            win_q     <= '0;
            ack_q     <= '0;
            err_q     <= '0;
            rr        <= '0;
        end else begin
            state     <= state_nxt;
            c_start_q <= C_start;
            ack_q     <= '0;
            err_q     <= '0;

            if (((state == IDLE) || (state == DONE)) && bal_load) begin
                bal <= bal_in;
            end

            if (enter_round) begin
                mask_q <= mask;
                cost_q <= bidcost;
                max_q  <= '0;
                win_q  <= '0;
            end

            if (gnt_any) begin
                ack_q[gnt_idx] <= 1'b1;
                err_q[gnt_idx] <= eval_err;
                if (charge) begin
                    bal[gnt_idx] <= sel_bal - cost_q;
                end
                if (eval_err == ERR_OK) begin
                    max_q <= sel_bid;
                    win_q <= NB'(1) << gnt_idx;
                end
                rr <= (gnt_idx == PW'(NB - 1)) ? '0 : gnt_idx + 1'b1;
            end

            if (state == SETTLE) begin
                for (int i = 0; i < NB; i++) begin
                    if (win_q[i]) begin
                        bal[i] <= bal[i] - max_q;
                    end
                end
            end
        end
    end

    assign bid_ack    = ack_q;
    assign bid_err    = err_q;
    assign balance    = bal;
    assign max_bid    = max_q;
    assign win        = win_q;
    assign round_over = (state == DONE);
    assign ready      = (state == IDLE) || (state == DONE);

endmodule

// File: tb/tb_bid_round_arbiter.sv
// tb_bid_round_arbiter: directed and random bidding rounds checked cycle by cycle against a transaction-level
// model of the auction rules (default build, no idle timeout).
module tb_bid_round_arbiter;

    localparam int DW = 32;
    localparam int NB = 3;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                C_start;
    logic [NB-1:0]       mask;
    logic [DW-1:0]       bidcost;
    logic                bal_load;
    logic [NB*DW-1:0]    bal_in;
    logic [NB-1:0]       bid_valid;
    logic [NB*DW-1:0]    bid_value;
    logic [NB-1:0]       bid_ack;
    logic [NB*2-1:0]     bid_err;
    logic [NB*DW-1:0]    balance;
    logic [DW-1:0]       max_bid;
    logic [NB-1:0]       win;
    logic                round_over;
    logic                ready;

    always #5 clk = ~clk;

    bid_round_arbiter #(.DATAWIDTH(DW), .NUMBIDDERS(NB), .IDLETIMEOUT(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .C_start    (C_start),
        .mask       (mask),
        .bidcost    (bidcost),
        .bal_load   (bal_load),
        .bal_in     (bal_in),
        .bid_valid  (bid_valid),
        .bid_value  (bid_value),
        .bid_ack    (bid_ack),
        .bid_err    (bid_err),
        .balance    (balance),
        .max_bid    (max_bid),
        .win        (win),
        .round_over (round_over),
        .ready      (ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Auction model: phase of the round, latched settings, balances and leader kept as plain integers.
    typedef enum {P_IDLE, P_ROUND, P_SETTLE, P_DONE} phase_t;
    phase_t        m_phase;
    bit            m_prev_start;
    bit [NB-1:0]   m_mask;
    longint        m_cost;
    longint        m_max;
    longint        m_bal [NB];
    int            m_win;
    int            m_rr;
    bit [NB-1:0]   m_ack;
    int            m_err [NB];

    // Per-bidder pending bids; the head is presented until one cycle after its ack.
    int            bidq [NB][$];
    bit [NB-1:0]   drop_now = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit     rise;
        int     g;
        int     j;
        longint b;
        longint v;
        if (!reset_n) begin
            m_phase      = P_IDLE;
            m_prev_start = 1'b0;
            m_mask       = '0;
            m_cost       = 0;
            m_max        = 0;
            m_win        = -1;
            m_rr         = 0;
            m_ack        = '0;
            for (int i = 0; i < NB; i++) begin
                m_bal[i] = 0;
                m_err[i] = 0;
            end
            return;
        end
        rise         = C_start && !m_prev_start;
        m_prev_start = C_start;
        g            = -1;
        case (m_phase)
            P_IDLE, P_DONE: begin
                if (bal_load) begin
                    for (int i = 0; i < NB; i++) m_bal[i] = bal_in[i*DW +: DW];
                end
                if (rise) begin
                    m_phase = P_ROUND;
                    m_mask  = mask;
                    m_cost  = bidcost;
                    m_max   = 0;
                    m_win   = -1;
                end
            end
            P_ROUND: begin
                for (int k = 0; k < NB; k++) begin
                    j = (m_rr + k) % NB;
                    if (g < 0 && bid_valid[j] && !m_ack[j]) g = j;
                end
                if (!C_start) m_phase = P_SETTLE;
            end
            P_SETTLE: begin
                if (m_win >= 0) m_bal[m_win] = m_bal[m_win] - m_max;
                m_phase = P_DONE;
            end
            default: ;
        endcase
        m_ack = '0;
        if (g >= 0) begin
            b        = m_bal[g];
            v        = bid_value[g*DW +: DW];
            m_ack[g] = 1'b1;
            if (!m_mask[g]) begin
                m_err[g] = 3;
            end else if (b < m_cost + v) begin
                m_err[g] = 2;
            end else begin
                m_bal[g] = b - m_cost;
                if (v <= m_max) begin
                    m_err[g] = 1;
                end else begin
                    m_err[g] = 0;
                    m_max    = v;
                    m_win    = g;
                end
            end
            m_rr = (g + 1) % NB;
        end
    endtask

    task automatic check_model();
        logic [NB-1:0] e_win;
        e_win = (m_win < 0) ? '0 : (NB'(1) << m_win);
        check("ack", bid_ack, m_ack);
        for (int i = 0; i < NB; i++) begin
            if (m_ack[i]) check($sformatf("err%0d", i), bid_err[i*2 +: 2], m_err[i]);
            check($sformatf("bal%0d", i), balance[i*DW +: DW], m_bal[i]);
        end
        check("max_bid", max_bid, m_max);
        check("win", win, e_win);
        check("round_over", round_over, m_phase == P_DONE);
        check("ready", ready, (m_phase == P_IDLE) || (m_phase == P_DONE));
    endtask

    task automatic cycle();
        for (int i = 0; i < NB; i++) begin
            if (drop_now[i] && bidq[i].size() > 0) void'(bidq[i].pop_front());
        end
        drop_now = m_ack;
        for (int i = 0; i < NB; i++) begin
            if (bidq[i].size() > 0) begin
                bid_valid[i]           = 1'b1;
                bid_value[i*DW +: DW]  = DW'(bidq[i][0]);
            end else begin
                bid_valid[i]           = 1'b0;
                bid_value[i*DW +: DW]  = '0;
            end
        end
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic load(input int x, input int y, input int z);
        bal_load = 1'b1;
        bal_in   = {DW'(z), DW'(y), DW'(x)};
        cycle();
        bal_load = 1'b0;
    endtask

    task automatic open_round(input logic [NB-1:0] m, input int cost);
        C_start = 1'b1;
        mask    = m;
        bidcost = DW'(cost);
        cycle();
    endtask

    task automatic close_round();
        C_start = 1'b0;
        run(3);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"}, bid_ack, 0);
        check({tag, "_err"}, bid_err, 0);
        check({tag, "_bal"}, balance, 0);
        check({tag, "_max"}, max_bid, 0);
        check({tag, "_win"}, win, 0);
        check({tag, "_round_over"}, round_over, 0);
        check({tag, "_ready"}, ready, 1);
    endtask

    int len;

    initial begin
        reset_n   = 1'b0;
        C_start   = 1'b0;
        bal_load  = 1'b0;
        mask      = '0;
        bidcost   = '0;
        bal_in    = '0;
        bid_valid = '0;
        bid_value = '0;
        run(2);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // Basic round: X 20, Y 30, Y wins and pays its bid on settle.
        load(100, 50, 10);
        open_round(3'b111, 1);
        bidq[0].push_back(20);
        bidq[1].push_back(30);
        cycle();
        check("s1_ack_x", bid_ack, 3'b001);
        check("s1_err_x", bid_err[1:0], 2'b00);
        cycle();
        check("s1_ack_y", bid_ack, 3'b010);
        check("s1_err_y", bid_err[3:2], 2'b00);
        run(2);
        close_round();
        check("s1_round_over", round_over, 1'b1);
        check("s1_win", win, 3'b010);
        check("s1_max", max_bid, 30);
        check("s1_bal_x", balance[31:0], 99);
        check("s1_bal_y", balance[63:32], 19);
        check("s1_bal_z", balance[95:64], 10);

        // Simultaneous requests from pointer 0 are served X, Y, Z, then X again.
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        load(100, 50, 10);
        open_round(3'b111, 1);
        bidq[0].push_back(5);
        bidq[1].push_back(6);
        bidq[2].push_back(7);
        cycle();
        check("s2_ack_1", bid_ack, 3'b001);
        cycle();
        check("s2_ack_2", bid_ack, 3'b010);
        cycle();
        check("s2_ack_3", bid_ack, 3'b100);
        bidq[0].push_back(9);
        bidq[1].push_back(8);
        cycle();
        check("s2_ack_wrap", bid_ack, 3'b001);
        run(4);
        close_round();

        // Insufficient funds, then an exactly affordable bid.
        load(100, 50, 10);
        open_round(3'b111, 1);
        bidq[2].push_back(10);
        cycle();
        check("s3_ack_z", bid_ack, 3'b100);
        check("s3_nofunds", bid_err[5:4], 2'b10);
        run(2);
        check("s3_bal_kept", balance[95:64], 10);
        bidq[2].push_back(9);
        cycle();
        check("s3_ok", bid_err[5:4], 2'b00);
        run(2);
        close_round();
        check("s3_bal_z", balance[95:64], 0);
        check("s3_win", win, 3'b100);
        check("s3_max", max_bid, 9);

        // Masked bidder, then an equal later bid loses.
        load(100, 50, 100);
        open_round(3'b101, 1);
        bidq[1].push_back(40);
        cycle();
        check("s4_ack_y", bid_ack, 3'b010);
        check("s4_masked", bid_err[3:2], 2'b11);
        run(2);
        check("s4_bal_y", balance[63:32], 50);
        bidq[0].push_back(40);
        cycle();
        check("s4_err_x", bid_err[1:0], 2'b00);
        run(2);
        bidq[2].push_back(40);
        cycle();
        check("s4_ack_z", bid_ack, 3'b100);
        check("s4_lowbid", bid_err[5:4], 2'b01);
        run(2);
        close_round();
        check("s4_win", win, 3'b001);
        check("s4_max", max_bid, 40);
        check("s4_bal_x", balance[31:0], 59);
        check("s4_bal_z", balance[95:64], 99);

        // Reset in mid-round abandons it.
        load(100, 50, 10);
        open_round(3'b111, 1);
        bidq[0].push_back(20);
        bidq[1].push_back(30);
        run(3);
        reset_n = 1'b0;
        C_start = 1'b0;
        cycle();
        check_reset_outputs("midreset");
        reset_n = 1'b1;
        run(4);
        check("midreset_no_round_over", round_over, 1'b0);

        // Requests outside a round get no ack.
        bidq[0].push_back(5);
        run(3);
        check("idle_no_ack", bid_ack, 3'b000);
        bidq[0].delete();
        cycle();

        // Random rounds.
        for (int r = 0; r < 25; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                load($urandom_range(0, 300), $urandom_range(0, 300), $urandom_range(0, 300));
            end
            open_round(3'($urandom_range(0, 7)), $urandom_range(0, 4));
            len = $urandom_range(6, 30);
            for (int c = 0; c < len; c++) begin
                for (int i = 0; i < NB; i++) begin
                    if (bidq[i].size() < 2 && $urandom_range(0, 2) == 0) begin
                        bidq[i].push_back($urandom_range(0, 150));
                    end
                end
                cycle();
            end
            C_start = 1'b0;
            run(2 + $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
